// File: rtl/mem_bus_router.sv
// Registered PicoRV32 memory-port router: decodes one request at a time to the RAM or
// peripheral window, returns a one-cycle ready pulse, and latches a sticky bus error.
// Define MEM_BUS_TIMEOUT_EN to abort hung slave accesses after TIMEOUT_CYCLES.
module mem_bus_router #(
  parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
  parameter logic [31:0] RAM_SIZE       = 32'h0000_4000,
  parameter logic [31:0] PER_BASE       = 32'h1000_0000,
  parameter logic [31:0] PER_SIZE       = 32'h0000_1000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_valid_mem,
  output logic        mem_instr_mem,
  output logic [31:0] mem_addr_mem,
  output logic [31:0] mem_wdata_mem,
  output logic [3:0]  mem_wstrb_mem,
  input  logic        mem_ready_mem,
  input  logic [31:0] mem_rdata_mem,
  output logic        mem_valid_per,
  output logic [31:0] mem_addr_per,
  output logic [31:0] mem_wdata_per,
  output logic [3:0]  mem_wstrb_per,
  input  logic        mem_ready_per,
  input  logic [31:0] mem_rdata_per,
  input  logic        err_clr,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {IDLE, FWD_RAM, FWD_PER, RESP} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_bus_router: TIMEOUT_CYCLES must be within 1..65535");
  end

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, wdata_reg, rdata_reg, rdata_next;
  logic [3:0]  wstrb_reg;
  logic        instr_reg;
  logic        ram_hit, per_hit, set_err;
  logic [31:0] err_src;

  // Subtracting the base first keeps the compare correct even when BASE+SIZE would wrap.
  assign ram_hit = (mem_addr - RAM_BASE) < RAM_SIZE;
  assign per_hit = (mem_addr - PER_BASE) < PER_SIZE;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_reg;
  logic        timeout;

  assign timeout = (cnt_reg == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      cnt_reg <= '0;
    else if (state_reg == FWD_RAM || state_reg == FWD_PER)
      cnt_reg <= cnt_reg + 16'd1;
    else
      cnt_reg <= '0;
  end
`endif

  always_comb begin
    state_next = state_reg;
    rdata_next = rdata_reg;
    set_err    = 1'b0;
    err_src    = mem_addr;
    case (state_reg)
      IDLE: begin
        if (mem_valid) begin
          if (ram_hit)
            state_next = FWD_RAM;
          else if (per_hit)
            state_next = FWD_PER;
          else begin
            state_next = RESP;
            rdata_next = 32'hDEAD_BEEF;
            set_err    = 1'b1;
          end
        end
      end
      FWD_RAM, FWD_PER: begin
        if ((state_reg == FWD_RAM) ? mem_ready_mem : mem_ready_per) begin
          state_next = RESP;
          rdata_next = (state_reg == FWD_RAM) ? mem_rdata_mem : mem_rdata_per;
        end
`ifdef MEM_BUS_TIMEOUT_EN
        else if (timeout) begin
          state_next = RESP;
          rdata_next = 32'hFFFF_FFFF;
          set_err    = 1'b1;
          err_src    = addr_reg;
        end
`endif
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      rdata_reg <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      instr_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      rdata_reg <= rdata_next;
      if (state_reg == IDLE && mem_valid) begin
        addr_reg  <= mem_addr;
        wdata_reg <= mem_wdata;
        wstrb_reg <= mem_wstrb;
        instr_reg <= mem_instr;
      end
    end
  end

  // A new error outranks a simultaneous clear; otherwise only the first error is kept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_err  <= 1'b0;
      err_addr <= '0;
    end else if (set_err && (!bus_err || err_clr)) begin
      bus_err  <= 1'b1;
      err_addr <= err_src;
    end else if (err_clr) begin
      bus_err  <= 1'b0;
      err_addr <= '0;
    end
  end

  assign mem_ready = (state_reg == RESP);
  assign mem_rdata = mem_ready ? rdata_reg : 32'h0;

  assign mem_valid_mem = (state_reg == FWD_RAM);
  assign mem_instr_mem = instr_reg;
  assign mem_addr_mem  = (addr_reg - RAM_BASE) & (RAM_SIZE - 32'd1);
  assign mem_wdata_mem = wdata_reg;
  assign mem_wstrb_mem = wstrb_reg;

  assign mem_valid_per = (state_reg == FWD_PER);
  assign mem_addr_per  = (addr_reg - PER_BASE) & (PER_SIZE - 32'd1);
  assign mem_wdata_per = wdata_reg;
  assign mem_wstrb_per = wstrb_reg;

endmodule
